adc_avg_sequencer: RTL and testbench

Downstream consumer and trigger source for the SAR conversion controller. On a `start` pulse it drives the controller's `go` for 2^LOG2_N back-to-back conversions, captures each `result` on `valid`, and accumulates the samples. It then presents one rounded average to the system over a valid/ready handshake. A per-conversion timeout guards against a stalled converter.

---
 rtl/adc_pkg.sv | 14 +
 rtl/adc_avg_sequencer.sv | 124 ++++++++++++
 tb/tb_adc_avg_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the SAR conversion path.
// Provides the default result width and the sequencer state type.
package adc_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/adc_avg_sequencer.sv
// Triggers 2^LOG2_N conversions, averages them with half-up rounding,
// and offers the result over a valid/ready handshake.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : request one averaged measurement (IDLE only)
//   adc_go            : conversion request to the controller
//   adc_valid         : one-cycle completion strobe from the controller
//   adc_result        : conversion value, qualified by adc_valid
//   avg, avg_valid    : rounded average and its valid flag
//   avg_ready         : consumer accepts avg
//   busy              : high whenever not IDLE
//   err               : one-cycle pulse on conversion timeout
module adc_avg_sequencer
  import adc_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned LOG2_N  = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             adc_go,
  input  logic             adc_valid,
  input  logic [WIDTH-1:0] adc_result,
  output logic [WIDTH-1:0] avg,
  output logic             avg_valid,
  input  logic             avg_ready,
  output logic             busy,
  output logic             err
);

  // One spare accumulator bit keeps the rounding add from wrapping.
  localparam int unsigned AW = WIDTH + LOG2_N + 1;
  localparam int unsigned CW = LOG2_N + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  localparam logic [CW-1:0] NSAMP = CW'(1 << LOG2_N);
  localparam logic [AW-1:0] HALF  = AW'(1) << (LOG2_N - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [WIDTH-1:0] avg_q, avg_d;
  logic             err_q, err_d;

  logic [AW-1:0] acc_sum;
  logic [CW-1:0] cnt_inc;

  assign acc_sum = acc_q + AW'(adc_result);
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    avg_d   = avg_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          acc_d   = '0;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end
      REQ: begin
        tmo_d = tmo_q + TW'(1);
        // A completion on the expiry cycle still counts.
        if (adc_valid) begin
          acc_d = acc_sum;
          cnt_d = cnt_inc;
          if (cnt_inc == NSAMP) begin
            state_d = DONE;
            avg_d   = WIDTH'((acc_sum + HALF) >> LOG2_N);
          end else begin
            state_d = GAP;
          end
        end else if (tmo_q == TLAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      GAP: begin
        // go drops for one cycle so the controller re-arms.
        tmo_d   = '0;
        state_d = REQ;
      end
      DONE: begin
        if (avg_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      avg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      avg_q   <= avg_d;
      err_q   <= err_d;
    end
  end

  assign adc_go    = (state_q == REQ);
  assign busy      = (state_q != IDLE);
  assign avg_valid = (state_q == DONE);
  assign avg       = avg_q;
  assign err       = err_q;

endmodule

// File: tb/tb_adc_avg_sequencer.sv
// Scoreboard bench for adc_avg_sequencer with a stub converter.
// Expected averages come from integer division of the issued samples.
module tb_adc_avg_sequencer;

  localparam int W   = 8;
  localparam int L   = 2;
  localparam int N   = 4;
  localparam int TMO = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         adc_go;
  logic         adc_valid;
  logic [W-1:0] adc_result;
  logic [W-1:0] avg;
  logic         avg_valid;
  logic         avg_ready;
  logic         busy;
  logic         err;

  always #5 clk = ~clk;

  adc_avg_sequencer #(
    .WIDTH(W), .LOG2_N(L), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .adc_go(adc_go), .adc_valid(adc_valid),
    .adc_result(adc_result), .avg(avg),
    .avg_valid(avg_valid), .avg_ready(avg_ready),
    .busy(busy), .err(err)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Stub converter
  logic [W-1:0] stub_q[$];
  bit stall = 0;
  bit armed = 0;
  int ccnt  = 0;
  int conv  = 1;

  initial begin
    adc_valid  = 1'b0;
    adc_result = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        adc_valid = 1'b0;
        stub_q.delete();
        armed = 0;
        ccnt  = 0;
      end else if (adc_valid) begin
        adc_valid  = 1'b0;
        adc_result = W'($urandom);
        armed      = !adc_go;
      end else if (!adc_go) begin
        armed = 1;
        ccnt  = 0;
        conv  = $urandom_range(1, 4);
      end else if (armed && !stall) begin
        if (ccnt >= conv - 1) begin
          adc_valid  = 1'b1;
          adc_result = (stub_q.size() > 0) ? stub_q.pop_front() : '0;
          armed      = 0;
        end else begin
          ccnt++;
        end
      end
    end
  end

  // Monitor / scoreboard
  int           exp_q[$];
  int           err_exp = 0;
  bit           hold_v = 0;
  logic [W-1:0] hold_avg;
  bit           go_prev = 0;
  bit           seen_hi = 0;
  int           low_len = 0;
  int           go_rises = 0;
  int           valids_seen = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (hold_v) begin
        chk("hold_valid", avg_valid, 1);
        chk("hold_avg", avg, hold_avg);
      end
      hold_v   = avg_valid && !avg_ready && !rst;
      hold_avg = avg;
      if (avg_valid && avg_ready && !rst) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL avg_unexpected: got %0d expected none", avg);
        end else begin
          chk("avg", avg, exp_q.pop_front());
        end
      end
      if (err) begin
        checks++;
        if (err_exp > 0) begin
          passed++;
          err_exp--;
        end else begin
          $display("FAIL err_unexpected: got 1 expected 0");
        end
      end
      if (adc_valid && adc_go) valids_seen++;
      if (!busy) begin
        seen_hi = 0;
        low_len = 0;
      end else if (adc_go) begin
        if (!go_prev) begin
          go_rises++;
          if (seen_hi) chk("go_gap", low_len, 1);
        end
        seen_hi = 1;
        low_len = 0;
      end else if (seen_hi) begin
        low_len++;
      end
      go_prev = adc_go;
    end
  end

  bit rnd_rdy = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) avg_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    if (busy) chk(nm, busy, 0);
  endtask

  task automatic issue(input logic [W-1:0] s[N], input bit expect_it);
    int sum = 0;
    for (int i = 0; i < N; i++) begin
      stub_q.push_back(s[i]);
      sum += int'(s[i]);
    end
    // round half-up: (sum + N/2) / N
    if (expect_it) exp_q.push_back((sum + N / 2) / N);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [W-1:0] sv[N];

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    avg_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_go", adc_go, 0);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_avg", avg, 0);
    tick();
    rst = 1'b0;
    tick();

    go_rises = 0;
    sv = '{8'h46, 8'h46, 8'h46, 8'h46};
    issue(sv, 1);
    wait_idle("idle_46");
    @(negedge clk);
    chk("go_phases", go_rises, N);

    sv = '{8'd10, 8'd11, 8'd12, 8'd13};
    issue(sv, 1);
    wait_idle("idle_a");
    sv = '{8'd1, 8'd1, 8'd1, 8'd2};
    issue(sv, 1);
    wait_idle("idle_b");
    sv = '{8'd255, 8'd255, 8'd255, 8'd255};
    issue(sv, 1);
    wait_idle("idle_ff");

    rnd_rdy = 1;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) sv[i] = W'($urandom);
      issue(sv, 1);
      wait_idle("idle_rnd");
      tick();
    end
    rnd_rdy   = 0;
    avg_ready = 1'b1;
    tick();

    begin : timeout_test
      int k = 0;
      int n = 0;
      stall   = 1;
      err_exp = 1;
      start   = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      while (!adc_go && k < 10) begin
        @(negedge clk);
        k++;
      end
      while (!err && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("err_delay", n, TMO);
      chk("go_after_err", adc_go, 0);
      chk("busy_after_err", busy, 0);
      @(negedge clk);
      chk("err_pulse", err, 0);
      stall = 0;
      tick();
    end

    for (int i = 0; i < N; i++) sv[i] = W'($urandom);
    issue(sv, 1);
    wait_idle("idle_after_err");

    begin : backpressure
      int k = 0;
      avg_ready = 1'b0;
      for (int i = 0; i < N; i++) sv[i] = W'($urandom);
      issue(sv, 1);
      while (!avg_valid && k < 500) begin
        tick();
        k++;
      end
      chk("bp_reach_done", avg_valid, 1);
      for (int i = 0; i < 20; i++) begin
        start = (i % 3 == 0);
        tick();
      end
      start = 1'b0;
      tick();
      chk("bp_busy", busy, 1);
      avg_ready = 1'b1;
      tick();
      chk("bp_release_busy", busy, 0);
      chk("bp_release_valid", avg_valid, 0);
      repeat (3) tick();
      chk("bp_no_queue_go", adc_go, 0);
      chk("bp_no_queue_busy", busy, 0);
    end

    begin : midrun_reset
      int k = 0;
      valids_seen = 0;
      sv = '{8'd200, 8'd201, 8'd202, 8'd203};
      issue(sv, 0);
      while (valids_seen < 2 && k < 200) begin
        tick();
        k++;
      end
      rst = 1'b1;
      tick();
      chk("mrst_busy", busy, 0);
      chk("mrst_go", adc_go, 0);
      chk("mrst_valid", avg_valid, 0);
      rst = 1'b0;
      tick();
      sv = '{8'd3, 8'd5, 8'd7, 8'd9};
      issue(sv, 1);
      wait_idle("idle_mrst");
    end

    repeat (4) tick();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("err_exp_drained", err_exp, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
